round_key_store: RTL
====================

# round_key_store

Buffers the eleven 128-bit AES-128 round keys produced one per round by the key-expansion stage. It replays them on demand in forward order (encryption) or reverse order (decryption). The block sits directly downstream of key expansion and feeds the AddRoundKey datapath, so the schedule is generated once per key and then reused without recomputation.

## Interface
- `KEY_W`, default 128: round-key width in bits.
- `NUM_KEYS`, default 11: number of stored round keys (round 0 through 10).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush: returns the block to EMPTY.
- `wr_en`  in  1  write strobe: `wr_key` is valid this cycle.
- `wr_key`  in  KEY_W  round key from key expansion, delivered in round order 0..10.
- `wr_cnt`  out  4  number of keys stored (0..11).
- `full`  out  1  all NUM_KEYS keys are stored; reads are permitted.
- `rd_start`  in  1  begins a read sweep and latches `rd_dir`.
- `rd_dir`  in  1  sweep direction: 0 = forward (index 0→10), 1 = reverse (index 10→0).
- `rd_req`  in  1  request the next key of the current sweep.
- `rd_key`  out  KEY_W  registered key output.
- `rd_index`  out  4  index of the key currently on `rd_key`.
- `rd_valid`  out  1  one-cycle strobe: `rd_key` and `rd_index` are valid.
- `rd_last`  out  1  set together with `rd_valid` on the final key of a sweep.
- `err`  out  1  sticky flag: a write arrived while FULL, or a read arrived while not FULL.

## Operation
- Storage: NUM_KEYS×KEY_W register array. Write pointer `wp` and read pointer `rp` are 4 bits each.
- States (2-bit encoding):
  - EMPTY = 0
  - FILL = 1
  - FULL = 2
- Transitions:
  - EMPTY→FILL on the first `wr_en`.
  - FILL→FULL when the 11th write is accepted.
  - Any state→EMPTY on `clear`.
- Write, in EMPTY or FILL:
  - `mem[wp] <= wr_key`, `wp <= wp+1`, `wr_cnt <= wr_cnt+1`.
  - When `wp == NUM_KEYS-1` is written, the state moves to FULL.
- Write in FULL: the key is dropped, storage is unchanged, and `err` is set.
- `rd_start`, in any state: `dir <= rd_dir`; `rp <= (rd_dir ? NUM_KEYS-1 : 0)`.
- `rd_req` in FULL:
  - `rd_key <= mem[rp]`, `rd_index <= rp`, `rd_valid <= 1`.
  - `rp` moves one step in the current direction.
  - On the end index (10 forward, 0 reverse): `rd_last <= 1` and `rp` reloads to the start index of the same direction. Sweeps repeat indefinitely.
- `rd_req` outside FULL: ignored, `rd_valid` stays 0, and `err` is set.
- Simultaneous events:
  - `clear` overrides `wr_en`, `rd_req` and `rd_start` in the same cycle. It does not clear `err`.
  - `rd_start` together with `rd_req`: the read uses the newly loaded start index, and `rp` then advances from that index.
  - `wr_en` together with `rd_req` in FILL: the write is accepted, the read is ignored, and `err` is set.
- `clear` resets `wp`, `rp`, `wr_cnt`, `full`, `rd_valid`, `rd_last` and `dir`. Storage contents are left unchanged and are unreadable until the block refills.
- `err` is cleared only by `rst_n`.

## Timing
- Reset values:
  - State EMPTY.
  - `wp`, `rp`, `wr_cnt` = 0; `dir` = 0.
  - `full`, `rd_valid`, `rd_last`, `err` = 0.
  - `rd_key` = 0, `rd_index` = 0.
  - Memory is not reset.
- Write: `wr_en` at edge N → stored at N. `wr_cnt` and `full` reflect the write from cycle N+1.
- Read latency is 1 cycle: `rd_req` sampled at edge N → `rd_key`/`rd_valid` high in cycle N+1.
  - `rd_valid` deasserts the next cycle unless `rd_req` is held.
  - Holding `rd_req` yields one key per cycle; a full sweep takes 11 cycles.
- A key written at edge N is readable by `rd_req` from edge N+1 at the earliest, and only once `full=1`.
- `rst_n` asserted mid-sweep or mid-fill: outputs go to their reset values immediately (asynchronous). The next write lands at index 0.

## Test plan
- Fill 11 FIPS-197 Appendix A.1 round keys (key `2b7e151628aed2a6abf7158809cf4f3c`), then forward sweep → `rd_index` 0..10. First `rd_key` = `2b7e1516…4f3c`, last = `d014f9a8c9ee2589e13f0cc8b6630ca6` with `rd_last=1`. `full=1` from the cycle after the 11th write.
- Reverse sweep (`rd_start`, `rd_dir=1`) with `rd_req` held for 22 cycles → indices 10..0 twice. `rd_last` pulses on index 0 in cycles 11 and 22. First key = `d014f9a8…0ca6`.
- 12th `wr_en` after FULL with `wr_key=128'hFFFF…` → `err=1`, `wr_cnt` stays 11, and a read of index 10 still returns `d014f9a8…0ca6`.
- `rd_req` after only 5 writes → no `rd_valid`, `err=1`, `wr_cnt=5`.
- `clear` asserted in the same cycle as `rd_req` and `wr_en` while FULL → `rd_valid=0` next cycle, `full=0`, `wr_cnt=0`. The following write lands at index 0.
- `rst_n` pulsed low mid-sweep (after index 4) → `rd_valid=0` and `full=0` during reset. After refill, a forward sweep starts at index 0.

Source files
------------

// File: rtl/round_key_store.sv
// Holds the eleven AES-128 round keys from key expansion and replays them
// forward (encrypt) or reverse (decrypt), one registered key per request.
module round_key_store #(
  parameter int KEY_W    = 128,
  parameter int NUM_KEYS = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  output logic [3:0]       wr_cnt,
  output logic             full,
  input  logic             rd_start,
  input  logic             rd_dir,
  input  logic             rd_req,
  output logic [KEY_W-1:0] rd_key,
  output logic [3:0]       rd_index,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

  state_e           state_q, state_d;
  logic [3:0]       wp_q, wp_d;
  logic [3:0]       rp_q, rp_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic [KEY_W-1:0] mem [NUM_KEYS];
  logic             memWe;

  logic [3:0]       startIdx;
  logic [3:0]       effRp;
  logic             effDir;
  logic [3:0]       endIdx;

  // A same-cycle rd_start redirects the read to the new sweep's start index.
  always_comb begin
    startIdx = rd_dir ? LAST_IDX : 4'd0;
    effRp    = rd_start ? startIdx : rp_q;
    effDir   = rd_start ? rd_dir : dir_q;
    endIdx   = effDir ? 4'd0 : LAST_IDX;
  end

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = err_q;
    memWe   = 1'b0;

    if (clear) begin
      state_d = EMPTY;
      wp_d    = 4'd0;
      rp_d    = 4'd0;
      cnt_d   = 4'd0;
      dir_d   = 1'b0;
    end else begin
      if (rd_start) begin
        dir_d = rd_dir;
        rp_d  = startIdx;
      end

      if (wr_en) begin
        if (state_q == FULL) begin
          err_d = 1'b1;
        end else begin
          memWe   = 1'b1;
          wp_d    = wp_q + 4'd1;
          cnt_d   = cnt_q + 4'd1;
          state_d = (wp_q == LAST_IDX) ? FULL : FILL;
        end
      end

      if (rd_req) begin
        if (state_q == FULL) begin
          key_d   = mem[effRp];
          idx_d   = effRp;
          valid_d = 1'b1;
          if (effRp == endIdx) begin
            last_d = 1'b1;
            rp_d   = effDir ? LAST_IDX : 4'd0;
          end else begin
            rp_d   = effDir ? (effRp - 4'd1) : (effRp + 4'd1);
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wp_q    <= 4'd0;
      rp_q    <= 4'd0;
      cnt_q   <= 4'd0;
      dir_q   <= 1'b0;
      key_q   <= '0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Key storage is deliberately left out of reset; it is unreadable until refilled.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wp_q] <= wr_key;
    end
  end

  assign wr_cnt   = cnt_q;
  assign full     = (state_q == FULL);
  assign rd_key   = key_q;
  assign rd_index = idx_q;
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign err      = err_q;

endmodule
